// File: rtl/miller_mod_decoder.sv
// Modified Miller decoder for ISO14443A PCD->PICC frames at 106 kb/s.
// Classifies X/Y/Z symbols from pause edges, assembles bytes with parity and detects EoF.
module miller_mod_decoder #(
  parameter int unsigned ETU_CLKS = 32,
  parameter int unsigned TOL      = 3,
  parameter int unsigned CW       = 6
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_enable,
  input  logic       in_pause,
  output logic       out_bit,
  output logic       out_bit_valid,
  output logic [7:0] out_byte,
  output logic       out_byte_valid,
  output logic       out_parity_err,
  output logic [3:0] out_last_bits,
  output logic       out_y_detected,
  output logic       out_err,
  output logic       out_busy
);

  localparam int unsigned HALF = ETU_CLKS / 2;
  localparam logic [CW-1:0] CntMax = CW'(ETU_CLKS - 1);
  localparam logic [CW-1:0] CntTol = CW'(TOL);
  localparam logic [CW-1:0] XLo    = CW'(HALF - TOL);
  localparam logic [CW-1:0] XHi    = CW'(HALF + TOL);
  localparam logic [CW-1:0] XLoad  = CW'(HALF + 1);
  localparam logic [CW-1:0] CntOne = CW'(1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e        state_q;
  logic          pause_d_q, en_d_q;
  logic [CW-1:0] cnt_q;
  logic          prev_q, sof_etu_q, edge_seen_q, edge_x_q;
  logic          pend_valid_q, pend_bit_q;
  logic [3:0]    idx_q;
  logic [7:0]    data_q;
  logic          par_pend_q, par_bit_q;

  logic pe, in_z_win, in_x_win, etu_end, edge_bad;
  logic sym_x, sym_z, sym_y, cls_err, cls_eof;

  always_comb begin
    pe       = in_pause & ~pause_d_q;
    in_z_win = (cnt_q <= CntTol);
    in_x_win = (cnt_q >= XLo) && (cnt_q <= XHi);
    etu_end  = (cnt_q == CntMax);
    edge_bad = pe & (edge_seen_q | ~(in_z_win | in_x_win));
    sym_y    = ~edge_seen_q;
    sym_x    = edge_seen_q & edge_x_q;
    sym_z    = edge_seen_q & ~edge_x_q;
    cls_err  = sym_z & prev_q;
    cls_eof  = sym_y & ~prev_q;
  end

  assign out_busy = (state_q == StRun);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q        <= StIdle;
      pause_d_q      <= 1'b0;
      en_d_q         <= 1'b0;
      cnt_q          <= '0;
      prev_q         <= 1'b0;
      sof_etu_q      <= 1'b0;
      edge_seen_q    <= 1'b0;
      edge_x_q       <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_bit_q     <= 1'b0;
      idx_q          <= '0;
      data_q         <= '0;
      par_pend_q     <= 1'b0;
      par_bit_q      <= 1'b0;
      out_bit        <= 1'b0;
      out_bit_valid  <= 1'b0;
      out_byte       <= '0;
      out_byte_valid <= 1'b0;
      out_parity_err <= 1'b0;
      out_last_bits  <= '0;
      out_y_detected <= 1'b0;
      out_err        <= 1'b0;
    end else begin
      pause_d_q      <= in_pause;
      en_d_q         <= in_enable;
      out_bit_valid  <= 1'b0;
      out_byte_valid <= 1'b0;
      out_y_detected <= 1'b0;
      out_err        <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pe) cnt_q <= CntOne;
          else if (cnt_q != CntMax) cnt_q <= cnt_q + CntOne;
          // Start on the enable rising edge so a held enable after an error does not retrigger.
          if (in_enable && !en_d_q) begin
            if (cnt_q < XLo) begin
              state_q      <= StRun;
              prev_q       <= 1'b0;
              sof_etu_q    <= 1'b1;
              edge_seen_q  <= 1'b1;
              edge_x_q     <= 1'b0;
              pend_valid_q <= 1'b0;
              idx_q        <= '0;
              data_q       <= '0;
              par_pend_q   <= 1'b0;
            end else begin
              out_err <= 1'b1;
            end
          end
        end
        StRun: begin
          cnt_q <= etu_end ? '0 : cnt_q + CntOne;
          if (!in_enable) begin
            state_q    <= StIdle;
            par_pend_q <= 1'b0;
          end else if (edge_bad) begin
            out_err    <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= CntOne;
            par_pend_q <= 1'b0;
          end else begin
            if (par_pend_q) begin
              out_byte_valid <= 1'b1;
              out_byte       <= data_q;
              out_last_bits  <= '0;
              out_parity_err <= ~(^data_q ^ par_bit_q);
              par_pend_q     <= 1'b0;
              data_q         <= '0;
            end
            if (pe) begin
              edge_seen_q <= 1'b1;
              edge_x_q    <= in_x_win;
              cnt_q       <= in_x_win ? XLoad : CntOne;
            end
            if (etu_end) begin
              edge_seen_q <= 1'b0;
              edge_x_q    <= 1'b0;
              sof_etu_q   <= 1'b0;
              // The SoF symbol's own ETU carries no data.
              if (!sof_etu_q) begin
                if (cls_err) begin
                  out_err <= 1'b1;
                  state_q <= StIdle;
                end else if (cls_eof) begin
                  out_y_detected <= 1'b1;
                  if (idx_q != 4'd0) begin
                    out_byte_valid <= 1'b1;
                    out_byte       <= data_q;
                    out_last_bits  <= idx_q;
                    out_parity_err <= 1'b0;
                  end
                  state_q <= StIdle;
                end else begin
                  prev_q       <= sym_x;
                  pend_bit_q   <= sym_x;
                  pend_valid_q <= 1'b1;
                  if (pend_valid_q) begin
                    out_bit       <= pend_bit_q;
                    out_bit_valid <= 1'b1;
                    if (!idx_q[3]) begin
                      data_q[idx_q[2:0]] <= pend_bit_q;
                      idx_q              <= idx_q + 4'd1;
                    end else begin
                      par_pend_q <= 1'b1;
                      par_bit_q  <= pend_bit_q;
                      idx_q      <= '0;
                    end
                  end
                end
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_miller_mod_decoder.sv
// Directed bench for miller_mod_decoder: drives Modified Miller pause patterns and
// checks decoded bits, bytes, EoF and error strobes against hand-computed values.
module tb_miller_mod_decoder;

  logic       clk = 1'b0;
  logic       rst, en, pause;
  logic       out_bit, out_bit_valid, out_byte_valid, out_parity_err;
  logic [7:0] out_byte;
  logic [3:0] out_last_bits;
  logic       out_y_detected, out_err, out_busy;

  always #5 clk = ~clk;

  miller_mod_decoder dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_enable      (en),
    .in_pause       (pause),
    .out_bit        (out_bit),
    .out_bit_valid  (out_bit_valid),
    .out_byte       (out_byte),
    .out_byte_valid (out_byte_valid),
    .out_parity_err (out_parity_err),
    .out_last_bits  (out_last_bits),
    .out_y_detected (out_y_detected),
    .out_err        (out_err),
    .out_busy       (out_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor, sampled just after each rising edge.
  int         bit_n = 0, byte_n = 0, y_n = 0, err_n = 0, clash_n = 0;
  logic       bit_log [0:63];
  logic [7:0] byte_v;
  logic [3:0] last_v;
  logic       perr_v;

  always @(posedge clk) begin
    #1;
    if (out_bit_valid && bit_n < 64) begin
      bit_log[bit_n] = out_bit;
      bit_n++;
    end
    if (out_byte_valid) begin
      byte_v = out_byte;
      last_v = out_last_bits;
      perr_v = out_parity_err;
      byte_n++;
    end
    if (out_y_detected) y_n++;
    if (out_err) err_n++;
    if (out_y_detected && (out_err || out_bit_valid)) clash_n++;
  end

  int b_bit, b_byte, b_y, b_err;

  task automatic mark();
    b_bit = bit_n; b_byte = byte_n; b_y = y_n; b_err = err_n;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      pause = 1'b0;
    end
  endtask

  // One symbol period of len clocks; a 4-clock pause starts at offset off (none if off < 0).
  task automatic sym(input int off, input int len, input int en_at);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      pause = (off >= 0) && (j >= off) && (j < off + 4);
      if (j == en_at) en = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    logic prev;
    prev = 1'b0;
    mark();
    sym(0, 32, 4);
    for (int i = 0; i < n; i++) begin
      if (bits[i]) begin
        sym(16, 32, -1);
        prev = 1'b1;
      end else if (prev) begin
        sym(-1, 32, -1);
        prev = 1'b0;
      end else begin
        sym(0, 32, -1);
      end
    end
    if (prev) sym(-1, 32, -1);
    else sym(0, 32, -1);
    sym(-1, 32, -1);
    idle(4);
    en = 1'b0;
    idle(2);
  endtask

  task automatic check_frame(input string t, input int nb, input logic [15:0] bits,
                             input int nby, input logic [7:0] b, input logic [3:0] last,
                             input logic perr, input int ny, input int ne);
    check_eq({t, "_nbits"}, bit_n - b_bit, nb);
    for (int i = 0; i < nb; i++)
      if (b_bit + i < 64) check_eq({t, "_bit"}, bit_log[b_bit + i], bits[i]);
    check_eq({t, "_nbytes"}, byte_n - b_byte, nby);
    if (nby > 0) begin
      check_eq({t, "_byte"}, byte_v, b);
      check_eq({t, "_last"}, last_v, last);
      check_eq({t, "_perr"}, perr_v, perr);
    end
    check_eq({t, "_ydet"}, y_n - b_y, ny);
    check_eq({t, "_err"}, err_n - b_err, ne);
    check_eq({t, "_busy"}, out_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pause = 1'b0;

    // Reset held with in_pause toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pause = ~pause;
      check_eq("rst_outs", {out_bit, out_bit_valid, out_byte, out_byte_valid, out_parity_err,
                            out_last_bits, out_y_detected, out_err, out_busy}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; pause = 1'b0;
    idle(40);

    // Short frame 0x26 (7 bits).
    send_frame(16'h0026, 7);
    check_frame("short", 7, 16'h0026, 1, 8'h26, 4'd7, 1'b0, 1, 0);

    // Full byte 0x93, good and bad parity.
    send_frame(16'h0193, 9);
    check_frame("par_ok", 9, 16'h0193, 1, 8'h93, 4'd0, 1'b0, 1, 0);
    send_frame(16'h0093, 9);
    check_frame("par_bad", 9, 16'h0093, 1, 8'h93, 4'd0, 1'b1, 1, 0);

    // X then Z: illegal sequence.
    mark();
    sym(0, 32, 4); sym(16, 32, -1); sym(0, 32, -1);
    idle(2);
    check_frame("xz", 0, 16'h0000, 0, 8'h00, 4'd0, 1'b0, 0, 1);
    en = 1'b0; idle(2);

    // Edge outside both windows.
    mark();
    sym(0, 32, 4); sym(8, 32, -1);
    check_frame("edge8", 0, 16'h0000, 0, 8'h00, 4'd0, 1'b0, 0, 1);
    en = 1'b0; idle(2);

    // X edges at the window limits HALF+3 and HALF-3; ETU length follows the resync.
    mark();
    sym(0, 32, 4); sym(19, 35, -1); sym(13, 29, -1); sym(-1, 32, -1); sym(-1, 32, -1);
    idle(4); en = 1'b0; idle(2);
    check_frame("xlim", 2, 16'h0003, 1, 8'h03, 4'd2, 1'b0, 1, 0);

    // Enable arriving late in the ETU.
    mark();
    idle(40);
    @(negedge clk); en = 1'b1;
    idle(3);
    check_frame("late_en", 0, 16'h0000, 0, 8'h00, 4'd0, 1'b0, 0, 1);
    en = 1'b0; idle(2);

    // Mid-frame reset, then a clean frame.
    sym(0, 32, 4); sym(16, 32, -1); sym(16, 32, -1); sym(-1, 32, -1);
    idle(5);
    mark();
    @(negedge clk); rst = 1'b1; en = 1'b0;
    idle(2);
    @(negedge clk); rst = 1'b0;
    idle(40);
    check_frame("mid_rst", 0, 16'h0000, 0, 8'h00, 4'd0, 1'b0, 0, 0);
    send_frame(16'h0026, 7);
    check_frame("after_rst", 7, 16'h0026, 1, 8'h26, 4'd7, 1'b0, 1, 0);

    // Enable dropped mid-frame, then a clean frame.
    sym(0, 32, 4); sym(16, 32, -1); sym(16, 32, -1);
    idle(5);
    mark();
    @(negedge clk); en = 1'b0;
    idle(60);
    check_frame("abort", 0, 16'h0000, 0, 8'h00, 4'd0, 1'b0, 0, 0);
    send_frame(16'h0026, 7);
    check_frame("after_abort", 7, 16'h0026, 1, 8'h26, 4'd7, 1'b0, 1, 0);

    check_eq("no_clash", clash_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
